sbox_port_arbiter: RTL

Sequences and shares the single four-lane S-box ROM read port between the two AES requesters: key expansion (K) and sub_shift (S). It latches the winning requester's four addresses and drives the ROM's `rd_en`/`addr0..3`. It waits for the ROM `done` and captures the four substituted bytes into per-requester holding registers. It then returns a one-cycle `done` pulse to the requester. It replaces the ad-hoc `sel_in*`/`sel_rd_en` muxing in the encryptor top level.

---
 rtl/sbox_port_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sbox_port_arbiter.sv
// Shares the single four-lane S-box ROM read port between key expansion (K) and sub_shift (S):
// arbitrates, latches the winner's addresses, waits for the ROM and returns the bytes with a done pulse.
module sbox_port_arbiter #(
    parameter int RR      = 1,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       k_req,
    input  logic [7:0] k_addr0,
    input  logic [7:0] k_addr1,
    input  logic [7:0] k_addr2,
    input  logic [7:0] k_addr3,
    output logic [7:0] k_data0,
    output logic [7:0] k_data1,
    output logic [7:0] k_data2,
    output logic [7:0] k_data3,
    output logic       k_done,

    input  logic       s_req,
    input  logic [7:0] s_addr0,
    input  logic [7:0] s_addr1,
    input  logic [7:0] s_addr2,
    input  logic [7:0] s_addr3,
    output logic [7:0] s_data0,
    output logic [7:0] s_data1,
    output logic [7:0] s_data2,
    output logic [7:0] s_data3,
    output logic       s_done,

    output logic       sb_rd_en,
    output logic [7:0] sb_addr0,
    output logic [7:0] sb_addr1,
    output logic [7:0] sb_addr2,
    output logic [7:0] sb_addr3,
    input  logic [7:0] sb_out0,
    input  logic [7:0] sb_out1,
    input  logic [7:0] sb_out2,
    input  logic [7:0] sb_out3,
    input  logic       sb_done,

    output logic       grant,
    output logic       busy,
    output logic       err
);
    localparam int         LANES    = 4;
    localparam bit         RR_EN    = (RR != 0);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_reg;
    logic       grant_reg;
    logic       last_reg;      // 0 = K, 1 = S; resets to S so K wins the first tie
    logic       rd_en_reg;
    logic       busy_reg;
    logic       k_done_reg;
    logic       s_done_reg;
    logic       err_reg;
    logic [7:0] cnt_reg;

    logic [LANES-1:0][7:0] k_addr_v;
    logic [LANES-1:0][7:0] s_addr_v;
    logic [LANES-1:0][7:0] sb_out_v;

    logic pick_s;
    logic grant_fire;
    logic capture;
    logic timeout_hit;

    assign k_addr_v = {k_addr3, k_addr2, k_addr1, k_addr0};
    assign s_addr_v = {s_addr3, s_addr2, s_addr1, s_addr0};
    assign sb_out_v = {sb_out3, sb_out2, sb_out1, sb_out0};

    // A lone request always wins; a tie goes to S only in round-robin mode after a K grant.
    assign pick_s      = s_req && (!k_req || (RR_EN && !last_reg));
    assign grant_fire  = (state_reg == IDLE) && !sb_done && (k_req || s_req);
    assign capture     = (state_reg == BUSY) && sb_done;
    assign timeout_hit = (state_reg == BUSY) && !sb_done && (cnt_reg == CNT_LAST);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0] addr_reg;
        logic [7:0] k_data_reg;
        logic [7:0] s_data_reg;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                addr_reg   <= 8'h00;
                k_data_reg <= 8'h00;
                s_data_reg <= 8'h00;
            end else begin
                if (grant_fire) begin
                    addr_reg <= pick_s ? s_addr_v[gi] : k_addr_v[gi];
                end
                if (capture && !grant_reg) begin
                    k_data_reg <= sb_out_v[gi];
                end
                if (capture && grant_reg) begin
                    s_data_reg <= sb_out_v[gi];
                end
            end
        end
    end

    // Counter counts BUSY cycles from the grant, so a timeout's done appears TIMEOUT+1 cycles after it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            grant_reg  <= 1'b0;
            last_reg   <= 1'b1;
            rd_en_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            k_done_reg <= 1'b0;
            s_done_reg <= 1'b0;
            err_reg    <= 1'b0;
            cnt_reg    <= 8'h00;
        end else begin
            k_done_reg <= 1'b0;
            s_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_fire) begin
                        grant_reg <= pick_s;
                        cnt_reg   <= 8'h00;
                        rd_en_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (capture || timeout_hit) begin
                        rd_en_reg  <= 1'b0;
                        err_reg    <= timeout_hit;
                        k_done_reg <= !grant_reg;
                        s_done_reg <= grant_reg;
                        state_reg  <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 8'h01;
                    end
                end
                RESP: begin
                    busy_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                    last_reg  <= grant_reg;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign sb_rd_en = rd_en_reg;
    assign sb_addr0 = g_lane[0].addr_reg;
    assign sb_addr1 = g_lane[1].addr_reg;
    assign sb_addr2 = g_lane[2].addr_reg;
    assign sb_addr3 = g_lane[3].addr_reg;

    assign k_data0 = g_lane[0].k_data_reg;
    assign k_data1 = g_lane[1].k_data_reg;
    assign k_data2 = g_lane[2].k_data_reg;
    assign k_data3 = g_lane[3].k_data_reg;
    assign s_data0 = g_lane[0].s_data_reg;
    assign s_data1 = g_lane[1].s_data_reg;
    assign s_data2 = g_lane[2].s_data_reg;
    assign s_data3 = g_lane[3].s_data_reg;

    assign k_done = k_done_reg;
    assign s_done = s_done_reg;
    assign grant  = grant_reg;
    assign busy   = busy_reg;
    assign err    = err_reg;
endmodule
